// File: rtl/pipe_mem_stage.sv
// Registered Y86-64 memory stage: valid/ready in and out, wait states, address checks, sticky halt.
// Define PIPE_MEM_ALIGN_CHECK_EN to treat unaligned accesses as address errors.
//
// state | meaning
// IDLE  | empty, ready for execute
// WAIT  | memory op counting down its wait states
// DONE  | result offered to writeback, held until consumed
module pipe_mem_stage #(
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [2:0]        in_stat,
  input  logic [3:0]        in_dstE,
  input  logic [3:0]        in_dstM,
  input  logic [DATA_W-1:0] in_valA,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [DATA_W-1:0] in_valP,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [2:0]        out_stat,
  output logic [DATA_W-1:0] out_valE,
  output logic [DATA_W-1:0] out_valM,
  output logic [3:0]        out_dstE,
  output logic [3:0]        out_dstM,
  output logic              halted
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'(DEPTH_BYTES - 8);
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [7:0]        mem [DEPTH_BYTES];

  logic              dec_rd, dec_wr, dec_mem, dec_err;
  logic [DATA_W-1:0] dec_addr, dec_wdata;
  logic [2:0]        dec_stat;

  logic [AW-1:0]     req_idx;
  logic [DATA_W-1:0] req_wdata;
  logic              req_rd, req_wr, req_err;

  logic              accept, commit, use_in, halt_set, mem_we;
  logic              c_rd, c_wr, c_err;
  logic [AW-1:0]     c_idx;
  logic [DATA_W-1:0] c_wdata, rd_data;

  always_comb begin
    dec_rd    = 1'b0;
    dec_wr    = 1'b0;
    dec_addr  = in_valE;
    dec_wdata = in_valA;
    case (in_icode)
      4'h5:       dec_rd = 1'b1;
      4'h9, 4'hB: begin dec_rd = 1'b1; dec_addr = in_valA; end
      4'h4, 4'hA: dec_wr = 1'b1;
      4'h8:       begin dec_wr = 1'b1; dec_wdata = in_valP; end
      default: ;
    endcase
  end

  assign dec_mem = dec_rd | dec_wr;
`ifdef PIPE_MEM_ALIGN_CHECK_EN
  assign dec_err = dec_mem && ((dec_addr > MAX_ADDR) || (dec_addr[2:0] != 3'd0));
`else
  assign dec_err = dec_mem && (dec_addr > MAX_ADDR);
`endif
  assign dec_stat = (in_stat == STAT_AOK && dec_err) ? STAT_ADR : in_stat;

  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign halt_set  = out_valid && out_ready && (out_stat != STAT_AOK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    commit    = 1'b0;
    use_in    = 1'b0;
    case (state)
      IDLE, DONE: begin
        in_ready = (state == IDLE) ? 1'b1 : out_ready;
        if (in_valid && in_ready) begin
          if (dec_mem && (WAIT_CYCLES > 0)) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = DONE;
            commit    = 1'b1;
            use_in    = 1'b1;
          end
        end else if (state == DONE && out_ready) begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-wait accesses commit straight from the inputs; otherwise from the latched request.
  assign c_rd    = use_in ? dec_rd : req_rd;
  assign c_wr    = use_in ? (dec_wr && in_stat == STAT_AOK) : req_wr;
  assign c_err   = use_in ? dec_err : req_err;
  assign c_idx   = use_in ? dec_addr[AW-1:0] : req_idx;
  assign c_wdata = use_in ? dec_wdata : req_wdata;
  assign mem_we  = commit && c_wr && !c_err && !(halted || halt_set);

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 8; k++) rd_data[8*k +: 8] = mem[c_idx + AW'(k)];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) mem[c_idx + AW'(k)] <= c_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_icode <= 4'h1;
      out_stat  <= STAT_AOK;
      out_valE  <= '0;
      out_valM  <= '0;
      out_dstE  <= 4'hF;
      out_dstM  <= 4'hF;
      halted    <= 1'b0;
      req_idx   <= '0;
      req_wdata <= '0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      if (accept) begin
        out_icode <= in_icode;
        out_stat  <= dec_stat;
        out_valE  <= in_valE;
        out_dstE  <= in_dstE;
        out_dstM  <= in_dstM;
        req_idx   <= dec_addr[AW-1:0];
        req_wdata <= dec_wdata;
        req_rd    <= dec_rd;
        req_wr    <= dec_wr && (in_stat == STAT_AOK);
        req_err   <= dec_err;
      end
      if (commit) out_valM <= (c_rd && !c_err) ? rd_data : '0;
      if (halt_set) halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_mem_stage.sv
// Randomized self-checking bench for pipe_mem_stage against a byte-array memory model.
module tb_pipe_mem_stage;
  localparam int W     = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_icode = 4'h1;
  logic [2:0]  in_stat = 3'd1;
  logic [3:0]  in_dstE = 4'hF;
  logic [3:0]  in_dstM = 4'hF;
  logic [63:0] in_valA = '0;
  logic [63:0] in_valE = '0;
  logic [63:0] in_valP = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_icode;
  logic [2:0]  out_stat;
  logic [63:0] out_valE;
  logic [63:0] out_valM;
  logic [3:0]  out_dstE;
  logic [3:0]  out_dstM;
  logic        halted;

  pipe_mem_stage #(.DATA_W(64), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_icode(in_icode), .in_stat(in_stat),
    .in_dstE(in_dstE), .in_dstM(in_dstM), .in_valA(in_valA), .in_valE(in_valE), .in_valP(in_valP),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode), .out_stat(out_stat),
    .out_valE(out_valE), .out_valM(out_valM), .out_dstE(out_dstE), .out_dstM(out_dstM),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_mem [DEPTH];
  bit         m_halted = 1'b0;

  function automatic logic [63:0] m_read(input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = m_mem[int'(a[15:0]) + k];
    return v;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One complete transaction: offer, wait for result, compare against the model, consume.
  task automatic do_op(input logic [3:0] ic, input logic [2:0] st, input logic [63:0] va,
                       input logic [63:0] ve, input logic [63:0] vp, input string nm);
    bit rd, wr, err;
    logic [63:0] addr, wd, exp_m;
    logic [2:0] exp_s;
    logic [3:0] de, dm;
    int lat, exp_lat, n;
    rd   = (ic == 4'h5 || ic == 4'h9 || ic == 4'hB);
    wr   = (ic == 4'h4 || ic == 4'h8 || ic == 4'hA);
    addr = (ic == 4'h9 || ic == 4'hB) ? va : ve;
    wd   = (ic == 4'h8) ? vp : va;
    err  = (rd || wr) && (addr > 64'(DEPTH - 8));
`ifdef PIPE_MEM_ALIGN_CHECK_EN
    if ((rd || wr) && addr[2:0] != 3'd0) err = 1'b1;
`endif
    exp_s   = (st == 3'd1 && err) ? 3'd3 : st;
    exp_m   = (rd && !err) ? m_read(addr) : 64'd0;
    exp_lat = (rd || wr) ? 1 + W : 1;
    de = 4'($urandom);
    dm = 4'($urandom);
    in_icode = ic; in_stat = st; in_valA = va; in_valE = ve; in_valP = vp;
    in_dstE = de; in_dstM = dm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin $display("FAIL %s accept: in_ready=%b want 1", nm, in_ready); n_bad++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat != exp_lat) begin $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat); n_bad++; end
    n_cmp++;
    if (out_stat !== exp_s) begin $display("FAIL %s stat: got %0d want %0d", nm, out_stat, exp_s); n_bad++; end
    n_cmp++;
    if (out_valM !== exp_m) begin $display("FAIL %s valM: got %h want %h", nm, out_valM, exp_m); n_bad++; end
    n_cmp++;
    if (out_valE !== ve || out_icode !== ic || out_dstE !== de || out_dstM !== dm) begin
      $display("FAIL %s passthru: got %h/%h/%h/%h want %h/%h/%h/%h", nm,
               out_valE, out_icode, out_dstE, out_dstM, ve, ic, de, dm);
      n_bad++;
    end
    if (wr && !err && st == 3'd1 && !m_halted)
      for (int k = 0; k < 8; k++) m_mem[int'(addr[15:0]) + k] = wd[8*k +: 8];
    @(posedge clk); #1;
    if (exp_s != 3'd1) m_halted = 1'b1;
    n_cmp++;
    if (halted !== m_halted) begin $display("FAIL %s halted: got %b want %b", nm, halted, m_halted); n_bad++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || halted !== 1'b0) begin
      $display("FAIL reset ctl: got rdy=%b vld=%b hlt=%b want 1 0 0", in_ready, out_valid, halted); n_bad++;
    end
    n_cmp++;
    if (out_icode !== 4'h1 || out_stat !== 3'd1 || out_dstE !== 4'hF || out_dstM !== 4'hF) begin
      $display("FAIL reset regs: got %h %h %h %h want 1 1 f f", out_icode, out_stat, out_dstE, out_dstM); n_bad++;
    end
    n_cmp++;
    if (out_valE !== 64'd0 || out_valM !== 64'd0) begin
      $display("FAIL reset data: got %h %h want 0 0", out_valE, out_valM); n_bad++;
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_init();
    for (int i = 0; i < DEPTH / 8; i++) do_op(4'h4, 3'd1, rnd64(), 64'(8 * i), 64'd0, "init");
  endtask

  task automatic test_write_read();
    do_op(4'h4, 3'd1, 64'h1122334455667788, 64'd16, 64'd0, "wr16");
    do_op(4'h5, 3'd1, 64'd0, 64'd16, 64'd0, "rd16");
    do_op(4'h5, 3'd1, 64'd0, 64'd9, 64'd0, "rd9");
  endtask

  task automatic test_nonmem();
    do_op(4'h6, 3'd1, rnd64(), 64'd7, rnd64(), "opq");
    do_op(4'h0, 3'd1, 64'd0, 64'd2000, 64'd0, "halt_op");
  endtask

  task automatic test_call_ret();
    do_op(4'h8, 3'd1, 64'd0, 64'd1016, 64'h40, "call");
    do_op(4'h9, 3'd1, 64'd1016, 64'd0, 64'd0, "ret");
    do_op(4'hB, 3'd1, 64'd1016, 64'd0, 64'd0, "popq_edge");
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_m, ve2;
    int n;
    exp_m = m_read(64'd40);
    out_ready = 1'b0;
    in_icode = 4'h5; in_stat = 3'd1; in_valE = 64'd40; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_valM !== exp_m || out_icode !== 4'h5) begin
        $display("FAIL bp_hold: got vld=%b rdy=%b valM=%h ic=%h want 1 0 %h 5",
                 out_valid, in_ready, out_valM, out_icode, exp_m);
        n_bad++;
      end
      @(posedge clk); #1;
    end
    ve2 = rnd64();
    in_icode = 4'h6; in_valE = ve2; in_dstE = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin $display("FAIL bp_ready: got %b want 1", in_ready); n_bad++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_valE !== ve2 || out_icode !== 4'h6 || out_valM !== 64'd0) begin
      $display("FAIL bp_next: got vld=%b valE=%h ic=%h valM=%h want 1 %h 6 0",
               out_valid, out_valE, out_icode, out_valM, ve2);
      n_bad++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unaligned();
    do_op(4'h5, 3'd1, 64'd0, 64'd12, 64'd0, "rd12");
  endtask

  task automatic test_reset_mid_wait();
    in_icode = 4'h4; in_stat = 3'd1; in_valA = rnd64(); in_valE = 64'd32; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || halted !== 1'b0) begin
      $display("FAIL rst_wait: got vld=%b rdy=%b hlt=%b want 0 1 0", out_valid, in_ready, halted); n_bad++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    m_halted = 1'b0;
    @(posedge clk); #1;
    do_op(4'h5, 3'd1, 64'd0, 64'd32, 64'd0, "rst_rd32");
  endtask

  task automatic test_halt();
    do_op(4'hA, 3'd1, rnd64(), 64'd1017, 64'd0, "push_err");
    do_op(4'h5, 3'd1, 64'd0, 64'd1016, 64'd0, "rd1016");
    do_op(4'h4, 3'd1, rnd64(), 64'd24, 64'd0, "wr_halted");
    do_op(4'h5, 3'd1, 64'd0, 64'd24, 64'd0, "rd24");
    do_op(4'h5, 3'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, "wrap");
    do_op(4'h6, 3'd2, rnd64(), rnd64(), 64'd0, "stat_pass");
  endtask

  task automatic test_stat_nowrite();
    do_op(4'h4, 3'd4, rnd64(), 64'd48, 64'd0, "ins_wr");
    do_op(4'h5, 3'd1, 64'd0, 64'd48, 64'd0, "ins_rd48");
    // a reset clears halt so the random phase starts with writes enabled
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_halted = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0] ic;
    logic [2:0] st;
    logic [63:0] addr, va, ve;
    int r;
    for (int i = 0; i < 80; i++) begin
      ic = 4'($urandom_range(0, 11));
      r = $urandom_range(0, 9);
      if (r <= 5)      addr = 64'(8 * $urandom_range(0, 127));
      else if (r <= 7) addr = 64'($urandom_range(0, 1016));
      else if (r == 8) begin
        case ($urandom_range(0, 3))
          0:       addr = 64'd1017;
          1:       addr = 64'd1024;
          2:       addr = 64'hFFFF_FFFF_FFFF_FFF8;
          default: addr = 64'h1_0000_0000;
        endcase
      end else addr = 64'd1016;
      va = (ic == 4'h9 || ic == 4'hB) ? addr : rnd64();
      ve = (ic == 4'h9 || ic == 4'hB) ? rnd64() : addr;
      st = ($urandom_range(0, 14) == 0) ? 3'(2 + $urandom_range(0, 2)) : 3'd1;
      do_op(ic, st, va, ve, rnd64(), "rand");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_nonmem();
    test_call_ret();
    test_backpressure();
    test_unaligned();
    test_reset_mid_wait();
    test_halt();
    test_stat_nowrite();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
